// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter that owns the select lines of a shared 4:1 mux.
//   Four requesters (a,b,c,d) compete for the path. The arbiter registers a one-hot grant
//   and the matching select {s1,s0}, and drives w from the granted input.
//   A hold counter caps how long one owner can keep the path while others wait.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-low
//   req    request vector, bit0=a .. bit3=d
//   a..d   data inputs, selected by {s1,s0} = 0..3
//   gnt    registered one-hot grant, same bit order as req
//   s1,s0  registered select MSB/LSB
//   busy   registered, high while a grant is active
//   w      combinational mux output, forced to 0 when busy is low
module rr_mux_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic [WIDTH-1:0] w
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [3:0]      gnt_q;
  logic [1:0]      sel_q;
  logic            busy_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] cnt_q;

  // First set bit of mask, scanning upward from start with wrap.
  // Scanning offsets high-to-low lets the lowest offset win.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    res = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + i[1:0];
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  logic [1:0] owner_nxt;
  logic [3:0] others;
  logic [1:0] pick_idle;
  logic [1:0] pick_rel;
  logic [1:0] pick_rot;

  always_comb begin
    owner_nxt = sel_q + 2'd1;
    others    = req & ~(4'b0001 << sel_q);
    pick_idle = pick(req, ptr_q);
    // On release the owner's bit is already clear, so req itself is the other-requester set.
    pick_rel  = pick(req, owner_nxt);
    pick_rot  = pick(others, owner_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      ptr_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q <= StGrant;
            gnt_q   <= 4'b0001 << pick_idle;
            sel_q   <= pick_idle;
            busy_q  <= 1'b1;
            cnt_q   <= CntOne;
          end
        end
        StGrant: begin
          if (!req[sel_q]) begin
            ptr_q <= owner_nxt;
            if (|req) begin
              gnt_q <= 4'b0001 << pick_rel;
              sel_q <= pick_rel;
              cnt_q <= CntOne;
            end else begin
              // Select is left as-is in idle; w is masked by busy.
              state_q <= StIdle;
              gnt_q   <= 4'b0000;
              busy_q  <= 1'b0;
            end
          end else if ((cnt_q == CntMax) && (|others)) begin
            ptr_q <= owner_nxt;
            gnt_q <= 4'b0001 << pick_rot;
            sel_q <= pick_rot;
            cnt_q <= CntOne;
          end else if (cnt_q < CntMax) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = busy_q;

  always_comb begin
    w = '0;
    if (busy_q) begin
      unique case (sel_q)
        2'd0: w = a;
        2'd1: w = b;
        2'd2: w = c;
        2'd3: w = d;
        default: w = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (WIDTH=1, MAX_HOLD=4).
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       a, b, c, d;
  logic [3:0] gnt;
  logic       s1, s0, busy;
  logic       w;

  int errors = 0;
  int checks = 0;

  rr_mux_arbiter #(
    .WIDTH    (1),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .busy  (busy),
    .w     (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic mux4(input logic [1:0] sel, input logic ia, input logic ib,
                                input logic ic, input logic id);
    case (sel)
      2'd0:    return ia;
      2'd1:    return ib;
      2'd2:    return ic;
      default: return id;
    endcase
  endfunction

  // Invariants and the output mux, checked every cycle away from the active edge.
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    check("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
    if (busy) check("gnt_matches_sel", 32'(gnt), 32'(4'b0001 << {s1, s0}));
    check("w_model", 32'(w), busy ? 32'(mux4({s1, s0}, a, b, c, d)) : 32'd0);
  end

  initial begin
    logic [1:0] k;

    // Reset with every requester asserting.
    rst_n = 1'b0;
    req   = 4'b1111;
    {a, b, c, d} = 4'b1111;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'({s1, s0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_w", 32'(w), 32'd0);
    tick();
    tick();
    check("rst_hold_gnt", 32'(gnt), 32'd0);

    // Full contention from reset: four cycles each, a,b,c,d then wrap to a.
    {a, b, c, d} = 4'b1010;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      k = 2'((i / 4) % 4);
      check($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(4'b0001 << k));
      check($sformatf("rr_sel_%0d", i), 32'({s1, s0}), 32'(k));
    end

    // Single requester c: a releases, c taken at the same edge, then held with no rotation.
    {a, b, c, d} = 4'b0010;
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("single_gnt_%0d", i), 32'(gnt), 32'h4);
      check($sformatf("single_sel_%0d", i), 32'({s1, s0}), 32'd2);
      check($sformatf("single_w_%0d", i), 32'(w), 32'd1);
    end
    req = 4'b0000;
    tick();
    check("single_drop_gnt", 32'(gnt), 32'd0);
    check("single_drop_busy", 32'(busy), 32'd0);
    check("idle_w", 32'(w), 32'd0);
    check("idle_keeps_sel", 32'({s1, s0}), 32'd2);

    // Early release: ptr=3 so a wins from idle; a drops, b taken with no idle cycle.
    {a, b, c, d} = 4'b0100;
    req = 4'b0001;
    tick();
    check("early_a_gnt", 32'(gnt), 32'h1);
    req = 4'b0110;
    tick();
    check("early_b_gnt", 32'(gnt), 32'h2);
    check("early_b_busy", 32'(busy), 32'd1);
    check("early_b_w", 32'(w), 32'd1);

    // Priority: drive to d, release to idle (ptr=0), then a beats d.
    req = 4'b0000;
    tick();
    check("prio_idle", 32'(busy), 32'd0);
    req = 4'b1000;
    tick();
    check("prio_d_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick();
    check("prio_d_rel", 32'(gnt), 32'd0);
    req = 4'b1001;
    tick();
    check("prio_a_first", 32'(gnt), 32'h1);

    // Async reset mid-grant with d owning the path.
    {a, b, c, d} = 4'b0001;
    req = 4'b1000;
    tick();
    check("async_pre_gnt", 32'(gnt), 32'h8);
    check("async_pre_w", 32'(w), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_sel", 32'({s1, s0}), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_w", 32'(w), 32'd0);
    req = 4'b0010;
    tick();
    check("async_held_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check("async_rel_no_grant_yet", 32'(gnt), 32'd0);
    tick();
    check("async_rel_gnt", 32'(gnt), 32'h2);
    check("async_rel_sel", 32'({s1, s0}), 32'd1);

    req = 4'b0000;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
